// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and constants for the cache/memory arbiter: FSM state
// encoding, bus-owner encoding, access size codes and the latched
// request record that is presented to memory.
package cache_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_ICACHE = 2'd1,
        OWN_DCACHE = 2'd2
    } owner_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Bit positions of the one-hot grant produced by the round-robin picker.
    localparam int GNT_ICACHE = 0;
    localparam int GNT_DCACHE = 1;

    // Fields held stable towards memory for the whole address phase.
    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] dout;
    } mem_req_t;

    // The Icache only ever issues full-word line reads, so everything but
    // the address is fixed.
    function automatic mem_req_t make_icache_req(input logic [31:0] addr);
        mem_req_t r;
        r       = '0;
        r.wr    = 1'b0;
        r.size  = SIZE_WORD;
        r.wstrb = 4'b0000;
        r.addr  = addr;
        r.dout  = 32'h0000_0000;
        return r;
    endfunction

    function automatic mem_req_t make_dcache_req(input logic        wr,
                                                 input logic [1:0]  size,
                                                 input logic [3:0]  wstrb,
                                                 input logic [31:0] addr,
                                                 input logic [31:0] dout);
        mem_req_t r;
        r.wr    = wr;
        r.size  = size;
        r.wstrb = wstrb;
        r.addr  = addr;
        r.dout  = dout;
        return r;
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of every handshake and bus signal between the two caches, the
// arbiter and the memory. The slave view belongs to the arbiter, the
// master view to whatever surrounds it (caches plus memory).
interface cache_mem_arbiter_if #(
    parameter int offset_width = 2
);
    localparam int LINE_W = 32 << offset_width;

    // Icache side
    logic              icache_mem_req;
    logic [31:0]       icache_mem_addr;
    logic              mem_icache_addrOK;
    logic              mem_icache_dataOK;
    logic [LINE_W-1:0] mem_icache_din;

    // Dcache side
    logic              dcache_mem_req;
    logic              dcache_mem_wr;
    logic [1:0]        dcache_mem_size;
    logic [3:0]        dcache_mem_wstrb;
    logic [31:0]       dcache_mem_addr;
    logic [31:0]       dcache_mem_dout;
    logic              mem_dcache_addrOK;
    logic              mem_dcache_dataOK;
    logic [LINE_W-1:0] mem_dcache_din;

    // Memory side
    logic              arb_mem_req;
    logic              arb_mem_wr;
    logic [1:0]        arb_mem_size;
    logic [3:0]        arb_mem_wstrb;
    logic [31:0]       arb_mem_addr;
    logic [31:0]       arb_mem_dout;
    logic              mem_arb_addrOK;
    logic              mem_arb_dataOK;
    logic [LINE_W-1:0] mem_arb_din;

    modport slave (
        input  icache_mem_req, icache_mem_addr,
        output mem_icache_addrOK, mem_icache_dataOK, mem_icache_din,
        input  dcache_mem_req, dcache_mem_wr, dcache_mem_size,
        input  dcache_mem_wstrb, dcache_mem_addr, dcache_mem_dout,
        output mem_dcache_addrOK, mem_dcache_dataOK, mem_dcache_din,
        output arb_mem_req, arb_mem_wr, arb_mem_size,
        output arb_mem_wstrb, arb_mem_addr, arb_mem_dout,
        input  mem_arb_addrOK, mem_arb_dataOK, mem_arb_din
    );

    modport master (
        output icache_mem_req, icache_mem_addr,
        input  mem_icache_addrOK, mem_icache_dataOK, mem_icache_din,
        output dcache_mem_req, dcache_mem_wr, dcache_mem_size,
        output dcache_mem_wstrb, dcache_mem_addr, dcache_mem_dout,
        input  mem_dcache_addrOK, mem_dcache_dataOK, mem_dcache_din,
        input  arb_mem_req, arb_mem_wr, arb_mem_size,
        input  arb_mem_wstrb, arb_mem_addr, arb_mem_dout,
        output mem_arb_addrOK, mem_arb_dataOK, mem_arb_din
    );

endinterface

// File: rtl/cache_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin picker. Purely combinational: when both requesters
// are active the one that was not served last wins; a lone requester
// always wins regardless of history.
module rr_arbiter2
    import cache_mem_arbiter_pkg::*;
(
    input  logic       req_icache,
    input  logic       req_dcache,
    input  logic       last_dcache,   // 1 = Dcache was granted most recently
    output logic [1:0] grant          // one-hot, see GNT_ICACHE / GNT_DCACHE
);

    // Pick at most one winner from the current requests and history.
    always_comb begin
        grant = 2'b00;
        if (req_icache && req_dcache) begin
            if (last_dcache) begin
                grant[GNT_ICACHE] = 1'b1;
            end else begin
                grant[GNT_DCACHE] = 1'b1;
            end
        end else if (req_dcache) begin
            grant[GNT_DCACHE] = 1'b1;
        end else if (req_icache) begin
            grant[GNT_ICACHE] = 1'b1;
        end else begin
            grant = 2'b00;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between an Icache (line reads) and a Dcache (line
// reads and word writes). One transaction at a time: grant in IDLE, hold
// the request towards memory in ADDR, wait for the data handshake in DATA.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int offset_width = 2
) (
    input  logic              clk,
    input  logic              rst,
    cache_mem_arbiter_if.slave bus
);

    localparam int LINE_W = 32 << offset_width;

    state_t      state_r;
    owner_t      owner_r;
    logic        last_dcache_r;
    logic        arb_req_r;
    mem_req_t    req_r;

    logic [1:0]        grant_s;
    logic              can_grant_s;
    logic              data_done_s;
    logic [LINE_W-1:0] line_s;

    rr_arbiter2 u_rr (
        .req_icache  (bus.icache_mem_req),
        .req_dcache  (bus.dcache_mem_req),
        .last_dcache (last_dcache_r),
        .grant       (grant_s)
    );

    // Grants and completions are suppressed while reset is held so that
    // every handshake output reads 0 during reset.
    assign can_grant_s = (state_r == ST_IDLE) && !rst;
    assign data_done_s = (state_r == ST_DATA) && bus.mem_arb_dataOK && !rst;

    // Accept pulses coincide with the IDLE cycle in which the grant is made.
    assign bus.mem_icache_addrOK = can_grant_s && grant_s[GNT_ICACHE];
    assign bus.mem_dcache_addrOK = can_grant_s && grant_s[GNT_DCACHE];

    // Completion is forwarded in the same cycle memory reports it.
    assign bus.mem_icache_dataOK = data_done_s && (owner_r == OWN_ICACHE);
    assign bus.mem_dcache_dataOK = data_done_s && (owner_r == OWN_DCACHE);

    // Returned line goes to both caches unconditionally; dataOK qualifies it.
    assign line_s             = bus.mem_arb_din;
    assign bus.mem_icache_din = line_s;
    assign bus.mem_dcache_din = line_s;

    // Memory request fields come straight from registers.
    assign bus.arb_mem_req   = arb_req_r;
    assign bus.arb_mem_wr    = req_r.wr;
    assign bus.arb_mem_size  = req_r.size;
    assign bus.arb_mem_wstrb = req_r.wstrb;
    assign bus.arb_mem_addr  = req_r.addr;
    assign bus.arb_mem_dout  = req_r.dout;

    // Transaction FSM: grant and latch in IDLE, address phase, data phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            owner_r       <= OWN_NONE;
            last_dcache_r <= 1'b0;
            arb_req_r     <= 1'b0;
            req_r         <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_s[GNT_DCACHE]) begin
                        req_r         <= make_dcache_req(bus.dcache_mem_wr,
                                                         bus.dcache_mem_size,
                                                         bus.dcache_mem_wstrb,
                                                         bus.dcache_mem_addr,
                                                         bus.dcache_mem_dout);
                        owner_r       <= OWN_DCACHE;
                        last_dcache_r <= 1'b1;
                        arb_req_r     <= 1'b1;
                        state_r       <= ST_ADDR;
                    end else if (grant_s[GNT_ICACHE]) begin
                        req_r         <= make_icache_req(bus.icache_mem_addr);
                        owner_r       <= OWN_ICACHE;
                        last_dcache_r <= 1'b0;
                        arb_req_r     <= 1'b1;
                        state_r       <= ST_ADDR;
                    end else begin
                        arb_req_r     <= 1'b0;
                        state_r       <= ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    // A dataOK arriving together with addrOK is not a
                    // completion; the real one follows in DATA.
                    if (bus.mem_arb_addrOK) begin
                        arb_req_r <= 1'b0;
                        state_r   <= ST_DATA;
                    end else begin
                        arb_req_r <= 1'b1;
                        state_r   <= ST_ADDR;
                    end
                end
                ST_DATA: begin
                    if (bus.mem_arb_dataOK) begin
                        owner_r <= OWN_NONE;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DATA;
                    end
                end
                default: begin
                    owner_r   <= OWN_NONE;
                    arb_req_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
